te_branch_map: RTL and testbench

Parametrised branch-map accumulator for the trace encoder. It collects per-retirement branch outcomes from up to `LANES` retire lanes per cycle into an `N_BRANCH`-bit map, and reports count, empty and full state, both registered (this cycle) and look-ahead (next cycle). The packet emitter consumes it as the branch-map source for format 1/2 packets and clears it with a flush on emission.

---
 rtl/te_pkg.sv | 17 +
 rtl/te_lane_rank.sv | 23 ++
 rtl/te_branch_map.sv | 96 +++++++++
 tb/tb_te_branch_map.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/te_pkg.sv
// Shared trace-encoder types and limits used by the branch-map accumulator.
package te_pkg;

  localparam int BRANCH_MAP_MAX = 31;
  localparam int LANES_MAX      = 4;
  localparam int LOST_CNT_LEN   = 16;
  localparam int BMAP_CNT_W     = $clog2(BRANCH_MAP_MAX + 1);
  localparam int LANE_CNT_W     = $clog2(LANES_MAX + 1);

  // Sized for the largest map so every parameterisation shares one layout
  typedef struct packed {
    logic [BRANCH_MAP_MAX-1:0] map;
    logic [BMAP_CNT_W-1:0]     count;
    logic                      overflow;
  } te_bmap_state_t;

endpackage

// File: rtl/te_lane_rank.sv
// Ranks the qualified branch lanes by lane index (lane 0 oldest) and counts them.
module te_lane_rank
  import te_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic [LANES-1:0]                 req_i,
  output logic [LANES-1:0][LANE_CNT_W-1:0] rank_o,
  output logic [LANE_CNT_W-1:0]            n_new_o
);

  always_comb begin
    logic [LANE_CNT_W-1:0] acc;
    acc    = '0;
    rank_o = '0;
    for (int k = 0; k < LANES; k++) begin
      rank_o[k] = acc;
      acc       = acc + LANE_CNT_W'(req_i[k]);
    end
    n_new_o = acc;
  end

endmodule

// File: rtl/te_branch_map.sv
// Branch-map accumulator: packs per-lane branch outcomes (1 = not taken) into a map.
// Optional run-level dropped-branch counter enabled by TE_BRANCH_MAP_LOST_CNT_EN.
module te_branch_map
  import te_pkg::*;
#(
  parameter int N_BRANCH = 31,
  parameter int LANES    = 1,
  parameter int CNT_W    = $clog2(N_BRANCH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic [LANES-1:0]    is_branch_i,
  input  logic [LANES-1:0]    taken_i,
  input  logic                flush_i,
  output logic [N_BRANCH-1:0] map_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                empty_next_o,
  output logic                full_next_o,
  output logic                overflow_o,
  output logic [15:0]         lost_cnt_o
);

  te_bmap_state_t                  state_q, state_d;
  logic [LANES-1:0]                req;
  logic [LANES-1:0][LANE_CNT_W-1:0] rank;
  logic [LANE_CNT_W-1:0]           n_new;
  logic [BMAP_CNT_W-1:0]           base, room, accept, drop;
  logic                            unused_state;

  assign req = is_branch_i & {LANES{valid_i}};

  te_lane_rank #(.LANES(LANES)) u_rank (
    .req_i  (req),
    .rank_o (rank),
    .n_new_o(n_new)
  );

  // Clamp new branches to the room left after an optional flush
  always_comb begin
    logic [BMAP_CNT_W-1:0] idx;
    idx     = '0;
    state_d = state_q;
    base    = flush_i ? '0 : state_q.count;
    room    = BMAP_CNT_W'(N_BRANCH) - base;
    accept  = (BMAP_CNT_W'(n_new) < room) ? BMAP_CNT_W'(n_new) : room;
    drop    = BMAP_CNT_W'(n_new) - accept;
    if (flush_i) begin
      state_d.map      = '0;
      state_d.overflow = 1'b0;
    end
    for (int k = 0; k < LANES; k++) begin
      if (req[k] && (BMAP_CNT_W'(rank[k]) < accept)) begin
        idx                = base + BMAP_CNT_W'(rank[k]);
        state_d.map[idx]   = ~taken_i[k];
      end
    end
    if (drop != '0) state_d.overflow = 1'b1;
    state_d.count = base + accept;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= '0;
    else         state_q <= state_d;
  end

`ifdef TE_BRANCH_MAP_LOST_CNT_EN
  logic [LOST_CNT_LEN-1:0] lost_q;
  logic [LOST_CNT_LEN:0]   lost_sum;

  assign lost_sum = {1'b0, lost_q} + (LOST_CNT_LEN + 1)'(drop);

  // Saturating; survives flushes so it reflects losses over the whole run
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               lost_q <= '0;
    else if (lost_sum[LOST_CNT_LEN]) lost_q <= '1;
    else                       lost_q <= lost_sum[LOST_CNT_LEN-1:0];
  end

  assign lost_cnt_o = lost_q;
`else
  assign lost_cnt_o = '0;
`endif

  assign map_o        = state_q.map[N_BRANCH-1:0];
  assign count_o      = CNT_W'(state_q.count);
  assign empty_o      = (state_q.count == '0);
  assign full_o       = (state_q.count == BMAP_CNT_W'(N_BRANCH));
  assign overflow_o   = state_q.overflow;
  assign empty_next_o = (state_d.count == '0);
  assign full_next_o  = (state_d.count == BMAP_CNT_W'(N_BRANCH));
  assign unused_state = ^{state_q.map, state_q.count};

endmodule

// File: tb/tb_te_branch_map.sv
// Bench for te_branch_map: a 31x1-lane instance and a 6x4-lane instance against a queue-style model.
module tb_te_branch_map;

  typedef struct {
    logic       flush;
    logic       valid;
    logic [3:0] isb;
    logic [3:0] tk;
    int         cnt;
    logic [5:0] map;
    logic       ovf;
  } vec_t;

  logic        clk, rst_n;
  logic        valid_a, flush_a, valid_b, flush_b;
  logic [0:0]  isb_a, tk_a;
  logic [3:0]  isb_b, tk_b;
  logic [30:0] map_a;
  logic [4:0]  cnt_a;
  logic [5:0]  map_b;
  logic [2:0]  cnt_b;
  logic        empty_a, full_a, en_a, fn_a, ovf_a;
  logic        empty_b, full_b, en_b, fn_b, ovf_b;
  logic [15:0] lost_a, lost_b;

  int          checks = 0;
  int          failures = 0;
  logic [30:0] m_map [2];
  int          m_cnt [2];
  logic        m_ovf [2];
  int          m_lost[2];
  vec_t        vecs[10];

  te_branch_map #(.N_BRANCH(31), .LANES(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_a), .is_branch_i(isb_a), .taken_i(tk_a),
    .flush_i(flush_a), .map_o(map_a), .count_o(cnt_a), .empty_o(empty_a), .full_o(full_a),
    .empty_next_o(en_a), .full_next_o(fn_a), .overflow_o(ovf_a), .lost_cnt_o(lost_a)
  );

  te_branch_map #(.N_BRANCH(6), .LANES(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_b), .is_branch_i(isb_b), .taken_i(tk_b),
    .flush_i(flush_b), .map_o(map_b), .count_o(cnt_b), .empty_o(empty_b), .full_o(full_b),
    .empty_next_o(en_b), .full_next_o(fn_b), .overflow_o(ovf_b), .lost_cnt_o(lost_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lost(input int i);
`ifdef TE_BRANCH_MAP_LOST_CNT_EN
    return m_lost[i];
`else
    return 0 * i;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_map[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_lost[i] = 0;
    end
  endtask

  // Branches are appended one at a time in lane order until the map is full
  task automatic model_step(input int i, input int n, input int lanes, input logic fl,
                            input logic v, input logic [3:0] b, input logic [3:0] t);
    if (fl) begin
      m_map[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
    end
    for (int k = 0; k < lanes; k++) begin
      if (v && b[k]) begin
        if (m_cnt[i] < n) begin
          m_map[i][m_cnt[i]] = ~t[k];
          m_cnt[i]++;
        end else begin
          m_ovf[i] = 1'b1;
          if (m_lost[i] < 65535) m_lost[i]++;
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic fa, input logic va, input logic ba, input logic ta,
                                input logic fb, input logic vb, input logic [3:0] bb,
                                input logic [3:0] tb);
    flush_a = fa; valid_a = va; isb_a = ba; tk_a = ta;
    flush_b = fb; valid_b = vb; isb_b = bb; tk_b = tb;
    model_step(0, 31, 1, fa, va, {3'b000, ba}, {3'b000, ta});
    model_step(1, 6, 4, fb, vb, bb, tb);
    #1;
    check("a_empty_next", en_a, m_cnt[0] == 0);
    check("a_full_next",  fn_a, m_cnt[0] == 31);
    check("b_empty_next", en_b, m_cnt[1] == 0);
    check("b_full_next",  fn_b, m_cnt[1] == 6);
  endtask

  task automatic check_output();
    @(posedge clk);
    #1;
    check("a_map",   map_a, m_map[0]);
    check("a_count", cnt_a, m_cnt[0]);
    check("a_empty", empty_a, m_cnt[0] == 0);
    check("a_full",  full_a, m_cnt[0] == 31);
    check("a_ovf",   ovf_a, m_ovf[0]);
    check("a_lost",  lost_a, exp_lost(0));
    check("b_map",   map_b, m_map[1][5:0]);
    check("b_count", cnt_b, m_cnt[1]);
    check("b_empty", empty_b, m_cnt[1] == 0);
    check("b_full",  full_b, m_cnt[1] == 6);
    check("b_ovf",   ovf_b, m_ovf[1]);
    check("b_lost",  lost_b, exp_lost(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a_map"}, map_a, 0);
    check({tag, "_a_count"}, cnt_a, 0);
    check({tag, "_a_empty"}, empty_a, 1);
    check({tag, "_a_full"}, full_a, 0);
    check({tag, "_a_ovf"}, ovf_a, 0);
    check({tag, "_a_lost"}, lost_a, 0);
    check({tag, "_b_map"}, map_b, 0);
    check({tag, "_b_count"}, cnt_b, 0);
    check({tag, "_b_empty"}, empty_b, 1);
    check({tag, "_b_ovf"}, ovf_b, 0);
    check({tag, "_b_lost"}, lost_b, 0);
  endtask

  initial begin
    logic [4:0] taken_seq;
    vecs[0] = '{1'b0, 1'b1, 4'b0111, 4'b0010, 3, 6'h05, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'b1011, 4'b0001, 3, 6'h06, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 3, 6'h06, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 4'b0001, 4'b0000, 4, 6'h0E, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'b1111, 4'b1010, 6, 6'h1E, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 4'b0100, 4'b0000, 6, 6'h1E, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 0, 6'h00, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 4'b0000, 4'b1111, 0, 6'h00, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4, 6'h0F, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 4'b1111, 4'b1111, 4, 6'h00, 1'b0};

    rst_n = 1'b0;
    flush_a = 0; valid_a = 0; isb_a = 0; tk_a = 0;
    flush_b = 0; valid_b = 0; isb_b = 0; tk_b = 0;
    model_reset();
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Five single-lane branches, taken = 1,0,0,1,1
    taken_seq = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 1, 1, taken_seq[i], 0, 0, 4'h0, 4'h0);
      check_output();
    end
    check("five_count", cnt_a, 5);
    check("five_map",   map_a[4:0], 5'b00110);
    check("five_empty", empty_a, 0);

    // Flush, then fill all 31 slots with not-taken branches
    apply_stimulus(1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output();
    check("flush_empty", empty_a, 1);
    for (int i = 0; i < 31; i++) begin
      apply_stimulus(0, 1, 1, 0, 0, 0, 4'h0, 4'h0);
      if (i == 30) begin
        check("fill_full_next_early", fn_a, 1);
        check("fill_full_still_low",  full_a, 0);
      end
      check_output();
    end
    check("fill_full", full_a, 1);
    check("fill_map",  map_a, 31'h7FFF_FFFF);

    // Two more branches while full are dropped
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 1, 1, 1, 0, 0, 4'h0, 4'h0);
      check_output();
    end
    check("drop_map", map_a, 31'h7FFF_FFFF);
    check("drop_ovf", ovf_a, 1);
`ifdef TE_BRANCH_MAP_LOST_CNT_EN
    check("drop_lost", lost_a, 2);
`else
    check("drop_lost", lost_a, 0);
`endif

    // Table-driven vectors on the 4-lane, 6-entry instance
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 0, 0, 0, vecs[i].flush, vecs[i].valid, vecs[i].isb, vecs[i].tk);
      check_output();
      check($sformatf("vec%0d_count", i), cnt_b, vecs[i].cnt);
      check($sformatf("vec%0d_map", i),   map_b, vecs[i].map);
      check($sformatf("vec%0d_ovf", i),   ovf_b, vecs[i].ovf);
      check($sformatf("vec%0d_full", i),  full_b, vecs[i].cnt == 6);
    end

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                     1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                     4'($urandom), 4'($urandom));
      check_output();
    end

    // Asynchronous reset mid-accumulation, checked before any clock edge
    apply_stimulus(0, 1, 1, 0, 0, 1, 4'b0011, 4'b0000);
    check_output();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    flush_a = 0; valid_a = 0; flush_b = 0; valid_b = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(0, 1, 1, 1, 0, 1, 4'b0001, 4'b0001);
    check_output();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
